// File: rtl/jtbubl_obj_pkg.sv
// Shared types and constants for the object tile drawer.
package jtbubl_obj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2
    } obj_st_e;

    localparam int PXL_PER_WORD = 8;
    localparam int BPP          = 4;

    // Pixel k of a ROM word: each bit plane sits in its own nibble,
    // pixels 0-3 in the low half-word and 4-7 in the high half-word.
    function automatic logic [BPP-1:0] obj_pxl(input logic [31:0] d, input logic [2:0] k);
        logic [BPP-1:0] p;
        p = '0;
        for (int b = 0; b < BPP; b++) begin
            p[b] = d[{k[2], 2'(b), k[1:0]}];
        end
        return p;
    endfunction

endpackage

// File: rtl/jtbubl_obj_fifo.sv
// Request queue: 2^QAW entries, pushes while full are dropped,
// flush empties the queue on the next edge.
module jtbubl_obj_fifo #(
    parameter int DW  = 8,
    parameter int QAW = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int           DEPTH    = 1 << QAW;
    localparam logic [QAW:0] FULL_CNT = (QAW+1)'(DEPTH);

    logic [DW-1:0]  mem_q [DEPTH];
    logic [QAW-1:0] wr_q, rd_q;
    logic [QAW:0]   cnt_q;
    logic           do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];

    // Storage array, written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // Pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + QAW'(1);
            if (do_pop)  rd_q <= rd_q + QAW'(1);
            cnt_q <= cnt_q + (QAW+1)'(do_push) - (QAW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/jtbubl_obj_draw.sv
// Object tile drawer: queues tile requests, fetches one 32-bit ROM word
// (8 pixels x 4 bpp) per tile and writes the 8 pixels to the line buffer.
// Optional JTBUBL_OBJ_TRANSP_EN: skip line-buffer writes for colour 4'hF.
module jtbubl_obj_draw
    import jtbubl_obj_pkg::*;
#(
    parameter int CW  = 10,
    parameter int BW  = 4,
    parameter int PW  = 4,
    parameter int HW  = 9,
    parameter int QAW = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              LHBL,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CW-1:0]     req_code,
    input  logic [BW-1:0]     req_bank,
    input  logic [PW-1:0]     req_pal,
    input  logic [HW-1:0]     req_hpos,
    input  logic [2:0]        req_vsub,
    input  logic              req_hflip,
    input  logic              req_vflip,
    output logic [BW+CW+3:0]  rom_addr,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [31:0]       rom_data,
    output logic [HW-1:0]     line_addr,
    output logic [PW+3:0]     line_din,
    output logic              line_we,
    output logic              busy
);
    localparam int            AW       = BW + CW + 4;
    localparam int            QW       = CW + BW + PW + HW + 5;
    localparam int            NW       = $clog2(PXL_PER_WORD);
    localparam logic [NW-1:0] LAST_PXL = NW'(PXL_PER_WORD - 1);

    logic [QW-1:0] q_din, q_dout;
    logic          q_push, q_pop, q_empty, q_full;

    logic [CW-1:0] h_code;
    logic [BW-1:0] h_bank;
    logic [PW-1:0] h_pal;
    logic [HW-1:0] h_hpos;
    logic [2:0]    h_vsub;
    logic          h_hflip, h_vflip;

    obj_st_e       st_q, st_d;
    logic [NW-1:0] cnt_q;
    logic          first_q;
    logic [AW-1:0] addr_q;
    logic [HW-1:0] hpos_q;
    logic [PW-1:0] pal_q;
    logic          hflip_q;
    logic [31:0]   data_q;
    logic          latch;

    logic [NW-1:0]  pix_idx;
    logic [BPP-1:0] raw;
    logic           drawing;

    // No requests are taken in reset or during horizontal blank
    assign req_ready = LHBL & ~q_full & ~rst;
    assign q_push    = req_valid & req_ready;
    assign q_din     = {req_code, req_bank, req_pal, req_hpos, req_vsub, req_hflip, req_vflip};
    assign {h_code, h_bank, h_pal, h_hpos, h_vsub, h_hflip, h_vflip} = q_dout;

    jtbubl_obj_fifo #(.DW(QW), .QAW(QAW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (~LHBL),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .din_i   (q_din),
        .dout_o  (q_dout),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    // Next state: pop on IDLE or at the last pixel, blank aborts everything
    always_comb begin
        st_d  = st_q;
        q_pop = 1'b0;
        latch = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop = 1'b1;
                    st_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // rom_ok in the first FETCH cycle belongs to an older access
                if (!first_q && rom_ok) begin
                    latch = 1'b1;
                    st_d  = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (cnt_q == LAST_PXL) begin
                    if (!q_empty) begin
                        q_pop = 1'b1;
                        st_d  = ST_FETCH;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
        if (!LHBL) begin
            st_d  = ST_IDLE;
            q_pop = 1'b0;
            latch = 1'b0;
        end
    end

    // State and per-tile registers; the request is captured when popped
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            addr_q  <= '0;
            hpos_q  <= '0;
            pal_q   <= '0;
            hflip_q <= 1'b0;
            data_q  <= '0;
        end else begin
            st_q    <= st_d;
            first_q <= q_pop;
            if (q_pop) begin
                addr_q  <= {h_bank, h_code, h_vsub ^ {3{h_vflip}}, 1'b0};
                hpos_q  <= h_hpos;
                pal_q   <= h_pal;
                hflip_q <= h_hflip;
                cnt_q   <= '0;
            end else if (st_q == ST_DRAW) begin
                cnt_q <= cnt_q + NW'(1);
            end
            if (latch) data_q <= rom_data;
        end
    end

    // Outputs are gated by blank and reset so an abort silences them at once
    always_comb begin
        pix_idx   = hflip_q ? ~cnt_q : cnt_q;
        raw       = obj_pxl(data_q, pix_idx);
        drawing   = (st_q == ST_DRAW) & LHBL & ~rst;
        rom_cs    = (st_q == ST_FETCH) & LHBL & ~rst;
        rom_addr  = addr_q;
        line_addr = drawing ? hpos_q + HW'(cnt_q) : '0;
        line_din  = drawing ? {pal_q, ~raw} : '0;
`ifdef JTBUBL_OBJ_TRANSP_EN
        line_we   = drawing & (raw != '0);
`else
        line_we   = drawing;
`endif
        busy      = ~q_empty | (st_q != ST_IDLE);
    end

endmodule

// File: tb/tb_jtbubl_obj_draw.sv
// Directed bench for jtbubl_obj_draw (default parameters).
module tb_jtbubl_obj_draw;
    localparam int CW = 10, BW = 4, PW = 4, HW = 9, QAW = 2;

    logic              clk = 1'b0;
    logic              rst, LHBL, req_valid, req_ready;
    logic [CW-1:0]     req_code;
    logic [BW-1:0]     req_bank;
    logic [PW-1:0]     req_pal;
    logic [HW-1:0]     req_hpos;
    logic [2:0]        req_vsub;
    logic              req_hflip, req_vflip;
    logic [BW+CW+3:0]  rom_addr;
    logic              rom_cs, rom_ok;
    logic [31:0]       rom_data;
    logic [HW-1:0]     line_addr;
    logic [PW+3:0]     line_din;
    logic              line_we, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0][7:0] ed;
    logic [8:0]      hp [5];
    int              d_st [5];
    int              cyc, pulses;

    always #5 clk = ~clk;

    jtbubl_obj_draw #(.CW(CW), .BW(BW), .PW(PW), .HW(HW), .QAW(QAW)) dut (
        .clk(clk), .rst(rst), .LHBL(LHBL),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_code(req_code), .req_bank(req_bank), .req_pal(req_pal),
        .req_hpos(req_hpos), .req_vsub(req_vsub),
        .req_hflip(req_hflip), .req_vflip(req_vflip),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .line_addr(line_addr), .line_din(line_din), .line_we(line_we), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] code, input logic [3:0] bank, input logic [3:0] pal,
                        input logic [8:0] hpos, input logic [2:0] vsub,
                        input logic hflip, input logic vflip);
        req_code = code; req_bank = bank; req_pal = pal; req_hpos = hpos;
        req_vsub = vsub; req_hflip = hflip; req_vflip = vflip;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // Leaves the bench in the first DRAW cycle of the next fetched tile
    task automatic wait_draw(input string tag);
        int k;
        k = 0;
        while (rom_cs !== 1'b1 && k < 50) begin step(); k++; end
        chk({tag, "_wait_cs"}, 32'(rom_cs), 1);
        k = 0;
        while (rom_cs !== 1'b0 && k < 50) begin step(); k++; end
        chk({tag, "_wait_draw"}, 32'(rom_cs), 0);
    endtask

    task automatic check_draw(input string tag, input logic [8:0] h, input logic [7:0][7:0] d);
        for (int n = 0; n < 8; n++) begin
            logic ew;
`ifdef JTBUBL_OBJ_TRANSP_EN
            ew = (d[n][3:0] != 4'hF);
`else
            ew = 1'b1;
`endif
            chk({tag, "_we"}, 32'(line_we), 32'(ew));
            chk({tag, "_addr"}, 32'(line_addr), 32'(9'(h + 9'(n))));
            chk({tag, "_din"}, 32'(line_din), 32'(d[n]));
            step();
        end
        chk({tag, "_gap_we"}, 32'(line_we), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; LHBL = 1'b1; req_valid = 1'b0;
        req_code = '0; req_bank = '0; req_pal = '0; req_hpos = '0;
        req_vsub = '0; req_hflip = 1'b0; req_vflip = 1'b0;
        rom_ok = 1'b0; rom_data = '0;
        step(); step();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cs", 32'(rom_cs), 0);
        chk("rst_we", 32'(line_we), 0);
        chk("rst_laddr", 32'(line_addr), 0);
        chk("rst_ldin", 32'(line_din), 0);
        chk("rst_raddr", 32'(rom_addr), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 1);

        // Tile A: address formation, stale ack, indefinite wait, no flip
        push(10'h155, 4'd3, 4'd5, 9'h010, 3'd2, 1'b0, 1'b1);
        chk("a_idle_busy", 32'(busy), 1);
        chk("a_idle_cs", 32'(rom_cs), 0);
        rom_ok = 1'b1; rom_data = 32'h0000_0001;
        step();
        chk("a_cs", 32'(rom_cs), 1);
        chk("a_rom_addr", 32'(rom_addr), 32'({4'd3, 10'h155, 3'd5, 1'b0}));
        step();
        chk("a_stale_ok", 32'(rom_cs), 1);
        rom_ok = 1'b0;
        repeat (3) begin
            step();
            chk("a_wait_cs", 32'(rom_cs), 1);
            chk("a_wait_addr", 32'(rom_addr), 32'({4'd3, 10'h155, 3'd5, 1'b0}));
        end
        rom_ok = 1'b1;
        step();
        rom_ok = 1'b0; rom_data = 32'hFFFF_FFFF;
        chk("a_cs_drop", 32'(rom_cs), 0);
        for (int n = 0; n < 8; n++) ed[n] = 8'h5F;
        ed[0] = 8'h5E;
        check_draw("a", 9'h010, ed);
        chk("a_end_busy", 32'(busy), 0);

        // Tile B: hflip moves pixel 0 to the last slot, x wraps past 1FF
        rom_ok = 1'b1; rom_data = 32'h0000_0001;
        push(10'h0AA, 4'd1, 4'd5, 9'h1FC, 3'd0, 1'b1, 1'b0);
        wait_draw("b");
        for (int n = 0; n < 8; n++) ed[n] = 8'h5F;
        ed[7] = 8'h5E;
        check_draw("b", 9'h1FC, ed);

        // Tile C: every pixel distinct per half, flipped
        rom_data = 32'h8421_8421;
        push(10'h001, 4'd0, 4'hA, 9'h040, 3'd7, 1'b1, 1'b0);
        wait_draw("c");
        ed[0] = 8'hA7; ed[1] = 8'hAB; ed[2] = 8'hAD; ed[3] = 8'hAE;
        ed[4] = 8'hA7; ed[5] = 8'hAB; ed[6] = 8'hAD; ed[7] = 8'hAE;
        check_draw("c", 9'h040, ed);

        // D: queue fills during a held fetch, fifth push dropped, 10-cycle tiles
        hp[0] = 9'h100; hp[1] = 9'h020; hp[2] = 9'h040; hp[3] = 9'h060; hp[4] = 9'h080;
        rom_ok = 1'b0;
        push(10'h010, 4'd2, 4'd1, hp[0], 3'd0, 1'b0, 1'b0);
        cyc = 0;
        while (rom_cs !== 1'b1 && cyc < 20) begin step(); cyc++; end
        chk("d_x_fetch", 32'(rom_cs), 1);
        for (int i = 1; i < 5; i++) begin
            req_hpos = hp[i]; req_valid = 1'b1;
            chk("d_ready", 32'(req_ready), 1);
            step();
        end
        req_hpos = 9'h0A0;
        chk("d_fifth_dropped", 32'(req_ready), 0);
        step();
        req_valid = 1'b0;
        rom_ok = 1'b1;
        for (int i = 0; i < 5; i++) d_st[i] = -1;
        cyc = 0; pulses = 0;
        while (busy && cyc < 200) begin
            step(); cyc++;
            if (line_we) begin
                pulses++;
                for (int i = 0; i < 5; i++) if (line_addr == hp[i]) d_st[i] = cyc;
            end
        end
        chk("d_pulses", pulses, 40);
        chk("d_busy_end", 32'(busy), 0);
        for (int i = 0; i < 4; i++) chk("d_spacing", d_st[i+1] - d_st[i], 10);

        // E: blank in mid-draw with two tiles still queued
        rom_data = 32'h8421_8421;
        push(10'h020, 4'd0, 4'd2, 9'h030, 3'd0, 1'b0, 1'b0);
        push(10'h021, 4'd0, 4'd2, 9'h0B0, 3'd0, 1'b0, 1'b0);
        push(10'h022, 4'd0, 4'd2, 9'h0D0, 3'd0, 1'b0, 1'b0);
        wait_draw("e");
        step(); step(); step();
        chk("e_d3_we", 32'(line_we), 1);
        chk("e_d3_addr", 32'(line_addr), 'h033);
        LHBL = 1'b0;
        step();
        chk("e_blank_we", 32'(line_we), 0);
        chk("e_blank_busy", 32'(busy), 0);
        chk("e_blank_cs", 32'(rom_cs), 0);
        chk("e_blank_ready", 32'(req_ready), 0);
        LHBL = 1'b1;
        repeat (4) begin
            step();
            chk("e_quiet_cs", 32'(rom_cs), 0);
            chk("e_quiet_busy", 32'(busy), 0);
        end
        push(10'h023, 4'd0, 4'd2, 9'h050, 3'd0, 1'b0, 1'b0);
        chk("e_new_idle_cs", 32'(rom_cs), 0);
        step();
        chk("e_new_cs", 32'(rom_cs), 1);
        cyc = 0;
        while (busy && cyc < 50) begin step(); cyc++; end
        chk("e_drain", 32'(busy), 0);

        // F: reset asserted in mid-draw
        push(10'h030, 4'd0, 4'd4, 9'h060, 3'd0, 1'b0, 1'b0);
        wait_draw("f");
        step(); step();
        rst = 1'b1;
        #1;
        chk("f_we_immediate", 32'(line_we), 0);
        step();
        chk("f_busy", 32'(busy), 0);
        chk("f_cs", 32'(rom_cs), 0);
        chk("f_we", 32'(line_we), 0);
        chk("f_laddr", 32'(line_addr), 0);
        chk("f_ldin", 32'(line_din), 0);
        chk("f_raddr", 32'(rom_addr), 0);
        chk("f_ready", 32'(req_ready), 0);
        rst = 1'b0;
        #1;
        chk("f_ready_after", 32'(req_ready), 1);
        pulses = 0;
        repeat (10) begin step(); if (line_we) pulses++; end
        chk("f_no_we", pulses, 0);

        // G: all-zero ROM word gives colour F on every pixel
        rom_data = 32'h0;
        push(10'h040, 4'd0, 4'd3, 9'h070, 3'd0, 1'b0, 1'b0);
        wait_draw("g");
        cyc = 0; pulses = 0;
        while (busy && cyc < 20) begin
            if (line_we) pulses++;
            cyc++;
            step();
        end
        chk("g_draw_len", cyc, 8);
`ifdef JTBUBL_OBJ_TRANSP_EN
        chk("g_pulses", pulses, 0);
`else
        chk("g_pulses", pulses, 8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
